// File: rtl/csr_counter_pkg.sv
// csr_counter_pkg: shared address map, enums and CSR op helpers for csr_counter_unit.
package csr_counter_pkg;

    localparam int CSR_COUNT_LEN = 64;
    localparam int CSR_XLEN      = 32;

    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

    localparam int CY_BIT = 0;
    localparam int IR_BIT = 2;

    typedef enum logic [1:0] {
        OP_READ = 2'd0,
        OP_RW   = 2'd1,
        OP_RS   = 2'd2,
        OP_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fsm_state_e;

    // An RS/RC with an all-zero mask is a pure read and never counts as a write.
    function automatic logic csr_op_writes(input csr_op_e op, input logic [CSR_XLEN-1:0] wdata);
        logic w;
        case (op)
            OP_RW:        w = 1'b1;
            OP_RS, OP_RC: w = (wdata != {CSR_XLEN{1'b0}});
            default:      w = 1'b0;
        endcase
        return w;
    endfunction

    // New register value produced by an op from the old value and the operand.
    function automatic logic [CSR_XLEN-1:0] csr_op_apply(input csr_op_e op,
                                                         input logic [CSR_XLEN-1:0] old_val,
                                                         input logic [CSR_XLEN-1:0] wdata);
        logic [CSR_XLEN-1:0] v;
        case (op)
            OP_RW:   v = wdata;
            OP_RS:   v = old_val | wdata;
            OP_RC:   v = old_val & ~wdata;
            default: v = old_val;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/csr_counter_unit_if.sv
// csr_counter_unit_if: execute-stage CSR request/response bus (req held until one-cycle ack).
interface csr_counter_unit_if #(
    parameter int XLEN = 32
);
    logic            csr_req;
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_ack;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_req, csr_addr, csr_op, csr_wdata,
        input  csr_ack, csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_req, csr_addr, csr_op, csr_wdata,
        output csr_ack, csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_counter_unit_cycle_counter.sv
// cycle_counter: free-running 64-bit mcycle with parallel load and inhibit; load wins over counting.
module cycle_counter #(
    parameter int COUNT_LEN = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [COUNT_LEN-1:0] i_load_data,
    input  logic                 i_inhibit,
    output logic [COUNT_LEN-1:0] o_count
);
    logic [COUNT_LEN-1:0] r_count;

    // Count every cycle unless loaded or inhibited; wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {COUNT_LEN{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_data;
        end else if (!i_inhibit) begin
            r_count <= r_count + {{(COUNT_LEN-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_counter_unit.sv
// csr_counter_unit: CSR decode/merge stage for mcycle, minstret and mcountinhibit.
// Optional macro CSR_COUNTER_HI_SNAPSHOT_EN: a lo-half read snapshots the upper half so the
// following hi read returns a value consistent with it (unless the counter was written).
module csr_counter_unit
    import csr_counter_pkg::*;
#(
    parameter int COUNT_LEN = CSR_COUNT_LEN,
    parameter int XLEN      = CSR_XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csr_counter_unit_if.slave    bus,
    input  logic                 i_retire,
    input  logic [COUNT_LEN-1:0] i_instret_in,
    output logic [COUNT_LEN-1:0] o_instret_data,
    output logic                 o_instret_load,
    output logic                 o_instret_inc
);
    fsm_state_e           r_state;
    logic [11:0]          r_addr;
    csr_op_e              r_op;
    logic [XLEN-1:0]      r_wdata;
    logic                 r_ack;
    logic [XLEN-1:0]      r_rdata;
    logic                 r_illegal;
    logic                 r_instret_load;
    logic [COUNT_LEN-1:0] r_instret_data;
    logic                 r_inh_cy;
    logic                 r_inh_ir;

    logic                 w_legal;
    logic                 w_alias;
    logic                 w_hi;
    logic                 w_is_cy;
    logic                 w_is_ir;
    logic                 w_is_inh;
    logic                 w_wr_req;
    logic                 w_do_wr;
    logic                 w_snap_hit;
    logic [XLEN-1:0]      w_snap_val;
    logic [COUNT_LEN-1:0] w_mcycle;
    logic [COUNT_LEN-1:0] w_live;
    logic [COUNT_LEN-1:0] w_merge;
    logic [XLEN-1:0]      w_inh_view;
    logic [XLEN-1:0]      w_live_half;
    logic [XLEN-1:0]      w_old;
    logic [XLEN-1:0]      w_new;
    logic                 w_cy_load;

    // Address decode of the latched request.
    always_comb begin
        w_legal  = 1'b1;
        w_alias  = 1'b0;
        w_hi     = 1'b0;
        w_is_cy  = 1'b0;
        w_is_ir  = 1'b0;
        w_is_inh = 1'b0;
        case (r_addr)
            ADDR_MCYCLE:        w_is_cy = 1'b1;
            ADDR_MCYCLEH:       begin w_is_cy = 1'b1; w_hi = 1'b1; end
            ADDR_MINSTRET:      w_is_ir = 1'b1;
            ADDR_MINSTRETH:     begin w_is_ir = 1'b1; w_hi = 1'b1; end
            ADDR_CYCLE:         begin w_is_cy = 1'b1; w_alias = 1'b1; end
            ADDR_CYCLEH:        begin w_is_cy = 1'b1; w_alias = 1'b1; w_hi = 1'b1; end
            ADDR_INSTRET:       begin w_is_ir = 1'b1; w_alias = 1'b1; end
            ADDR_INSTRETH:      begin w_is_ir = 1'b1; w_alias = 1'b1; w_hi = 1'b1; end
            ADDR_MCOUNTINHIBIT: w_is_inh = 1'b1;
            default:            w_legal = 1'b0;
        endcase
    end

`ifdef CSR_COUNTER_HI_SNAPSHOT_EN
    logic            r_snap_cy_v;
    logic            r_snap_ir_v;
    logic [XLEN-1:0] r_snap_cy;
    logic [XLEN-1:0] r_snap_ir;

    // A non-writing hi access uses the pending snapshot of its counter, if any.
    always_comb begin
        w_snap_hit = 1'b0;
        w_snap_val = r_snap_ir;
        if (w_is_cy) begin
            w_snap_hit = w_hi & ~w_do_wr & r_snap_cy_v;
            w_snap_val = r_snap_cy;
        end else if (w_is_ir) begin
            w_snap_hit = w_hi & ~w_do_wr & r_snap_ir_v;
            w_snap_val = r_snap_ir;
        end else begin
            w_snap_hit = 1'b0;
        end
    end

    // Lo reads capture the upper half; hi reads consume it; counter writes invalidate it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_cy_v <= 1'b0;
            r_snap_ir_v <= 1'b0;
            r_snap_cy   <= {XLEN{1'b0}};
            r_snap_ir   <= {XLEN{1'b0}};
        end else if (r_state == EXEC && w_legal) begin
            if (w_is_cy) begin
                if (!w_do_wr && !w_hi) begin
                    r_snap_cy_v <= 1'b1;
                    r_snap_cy   <= w_live[COUNT_LEN-1:XLEN];
                end else begin
                    r_snap_cy_v <= 1'b0;
                end
            end
            if (w_is_ir) begin
                if (!w_do_wr && !w_hi) begin
                    r_snap_ir_v <= 1'b1;
                    r_snap_ir   <= w_live[COUNT_LEN-1:XLEN];
                end else begin
                    r_snap_ir_v <= 1'b0;
                end
            end
        end
    end
`else
    // Without snapshots hi reads always see the live upper half.
    always_comb begin
        w_snap_hit = 1'b0;
        w_snap_val = {XLEN{1'b0}};
    end
`endif

    // Old value, new value and the 64-bit merge that a half write produces.
    always_comb begin
        w_wr_req   = csr_op_writes(r_op, r_wdata);
        w_do_wr    = w_legal & w_wr_req & ~w_alias;
        w_inh_view = {{(XLEN-3){1'b0}}, r_inh_ir, 1'b0, r_inh_cy};
        if (w_is_cy) begin
            w_live = w_mcycle;
        end else begin
            w_live = i_instret_in;
        end
        if (w_is_inh) begin
            w_live_half = w_inh_view;
        end else if (w_hi) begin
            w_live_half = w_live[COUNT_LEN-1:XLEN];
        end else begin
            w_live_half = w_live[XLEN-1:0];
        end
        if (w_snap_hit) begin
            w_old = w_snap_val;
        end else begin
            w_old = w_live_half;
        end
        w_new = csr_op_apply(r_op, w_old, r_wdata);
        if (w_hi) begin
            w_merge = {w_new, w_live[XLEN-1:0]};
        end else begin
            w_merge = {w_live[COUNT_LEN-1:XLEN], w_new};
        end
        w_cy_load = (r_state == EXEC) & w_do_wr & w_is_cy;
    end

    // Request FSM: latch in IDLE, resolve in EXEC, pulse ack/load during RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_addr         <= 12'h000;
            r_op           <= OP_READ;
            r_wdata        <= {XLEN{1'b0}};
            r_ack          <= 1'b0;
            r_rdata        <= {XLEN{1'b0}};
            r_illegal      <= 1'b0;
            r_instret_load <= 1'b0;
            r_instret_data <= {COUNT_LEN{1'b0}};
            r_inh_cy       <= 1'b0;
            r_inh_ir       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack          <= 1'b0;
                    r_instret_load <= 1'b0;
                    if (bus.csr_req) begin
                        r_addr  <= bus.csr_addr;
                        r_op    <= csr_op_e'(bus.csr_op);
                        r_wdata <= bus.csr_wdata;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_ack          <= 1'b1;
                    r_illegal      <= ~w_legal | (w_alias & w_wr_req);
                    r_rdata        <= w_legal ? w_old : {XLEN{1'b0}};
                    r_instret_load <= w_do_wr & w_is_ir;
                    if (w_do_wr && w_is_ir) begin
                        r_instret_data <= w_merge;
                    end
                    if (w_do_wr && w_is_inh) begin
                        r_inh_cy <= w_new[CY_BIT];
                        r_inh_ir <= w_new[IR_BIT];
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_ack          <= 1'b0;
                    r_instret_load <= 1'b0;
                    r_state        <= IDLE;
                end
                default: begin
                    r_ack          <= 1'b0;
                    r_instret_load <= 1'b0;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

    cycle_counter #(
        .COUNT_LEN (COUNT_LEN)
    ) u_cycle_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_cy_load),
        .i_load_data (w_merge),
        .i_inhibit   (r_inh_cy),
        .o_count     (w_mcycle)
    );

    assign bus.csr_ack     = r_ack;
    assign bus.csr_rdata   = r_rdata;
    assign bus.csr_illegal = r_illegal;
    assign o_instret_data  = r_instret_data;
    assign o_instret_load  = r_instret_load;
    // A CSR load to instret drops the retire of the same cycle; held low during reset.
    assign o_instret_inc   = rst_n & i_retire & ~r_inh_ir & ~r_instret_load;
endmodule

// File: tb/tb_csr_counter_unit.sv
// tb_csr_counter_unit: directed plus randomized checks against a transaction-level model.
module tb_csr_counter_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        retire;
    logic [63:0] instret_in;
    logic [63:0] instret_data;
    logic        instret_load;
    logic        instret_inc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: mcycle value, inhibit bits, hi-half snapshots.
    logic [63:0] m_cycle;
    logic        m_inh_cy, m_inh_ir;
    logic        m_snap_cy_v, m_snap_ir_v;
    logic [31:0] m_snap_cy, m_snap_ir;

    always #5 clk = ~clk;

    csr_counter_unit_if #(.XLEN(32)) bus ();

    csr_counter_unit #(.COUNT_LEN(64), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .i_retire       (retire),
        .i_instret_in   (instret_in),
        .o_instret_data (instret_data),
        .o_instret_load (instret_load),
        .o_instret_inc  (instret_inc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cycle = 64'd0; m_inh_cy = 1'b0; m_inh_ir = 1'b0;
        m_snap_cy_v = 1'b0; m_snap_ir_v = 1'b0; m_snap_cy = 32'd0; m_snap_ir = 32'd0;
    endtask

    // One clock edge; the model counts mcycle unless inhibited or written at this edge.
    task automatic advance(input logic cy_wr, input logic [63:0] cy_val);
        @(posedge clk);
        if (cy_wr) m_cycle = cy_val;
        else if (!m_inh_cy) m_cycle = m_cycle + 64'd1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            retire = 1'($urandom_range(0, 1));
            #1;
            chk("idle_inc", 64'(instret_inc), 64'(retire & ~m_inh_ir));
            chk("idle_ack", 64'(bus.csr_ack), 64'd0);
            advance(1'b0, 64'd0);
        end
        retire = 1'b0;
    endtask

    task automatic csr_txn(input logic [11:0] addr, input logic [1:0] op,
                           input logic [31:0] wdata, input logic ret);
        logic        legal, ro, hi, is_cy, is_ir, is_inh, writes;
        logic        exp_ill, exp_load, cy_wr, inh_wr;
        logic [31:0] old_v, new_v, exp_rdata;
        logic [63:0] live, merged;
        bus.csr_req = 1'b1; bus.csr_addr = addr; bus.csr_op = op; bus.csr_wdata = wdata;
        advance(1'b0, 64'd0);
        chk("ack_early", 64'(bus.csr_ack), 64'd0);
        legal = 1'b1; ro = 1'b0; hi = 1'b0; is_cy = 1'b0; is_ir = 1'b0; is_inh = 1'b0;
        case (addr)
            12'hB00: is_cy = 1'b1;
            12'hB80: begin is_cy = 1'b1; hi = 1'b1; end
            12'hB02: is_ir = 1'b1;
            12'hB82: begin is_ir = 1'b1; hi = 1'b1; end
            12'hC00: begin is_cy = 1'b1; ro = 1'b1; end
            12'hC80: begin is_cy = 1'b1; ro = 1'b1; hi = 1'b1; end
            12'hC02: begin is_ir = 1'b1; ro = 1'b1; end
            12'hC82: begin is_ir = 1'b1; ro = 1'b1; hi = 1'b1; end
            12'h320: is_inh = 1'b1;
            default: legal = 1'b0;
        endcase
        writes   = (op == 2'd1) || (op != 2'd0 && wdata != 32'd0);
        exp_ill  = !legal || (ro && writes);
        exp_load = 1'b0; cy_wr = 1'b0; inh_wr = 1'b0;
        exp_rdata = 32'd0; merged = 64'd0; new_v = 32'd0;
        live = is_cy ? m_cycle : instret_in;
        if (legal) begin
            if (is_inh) old_v = {29'd0, m_inh_ir, 1'b0, m_inh_cy};
            else if (hi) old_v = live[63:32];
            else old_v = live[31:0];
`ifdef CSR_COUNTER_HI_SNAPSHOT_EN
            if (is_cy) begin
                if (writes && !ro) m_snap_cy_v = 1'b0;
                else if (!hi) begin m_snap_cy_v = 1'b1; m_snap_cy = live[63:32]; end
                else begin if (m_snap_cy_v) old_v = m_snap_cy; m_snap_cy_v = 1'b0; end
            end
            if (is_ir) begin
                if (writes && !ro) m_snap_ir_v = 1'b0;
                else if (!hi) begin m_snap_ir_v = 1'b1; m_snap_ir = live[63:32]; end
                else begin if (m_snap_ir_v) old_v = m_snap_ir; m_snap_ir_v = 1'b0; end
            end
`endif
            exp_rdata = old_v;
            if (writes && !ro) begin
                if (op == 2'd1) new_v = wdata;
                else if (op == 2'd2) new_v = old_v | wdata;
                else new_v = old_v & ~wdata;
                merged   = hi ? {new_v, live[31:0]} : {live[63:32], new_v};
                exp_load = is_ir; cy_wr = is_cy; inh_wr = is_inh;
            end
        end
        retire = ret;
        #1;
        chk("inc_exec", 64'(instret_inc), 64'(ret & ~m_inh_ir));
        advance(cy_wr, merged);
        if (inh_wr) begin m_inh_cy = new_v[0]; m_inh_ir = new_v[2]; end
        chk("ack", 64'(bus.csr_ack), 64'd1);
        chk("rdata", 64'(bus.csr_rdata), 64'(exp_rdata));
        chk("illegal", 64'(bus.csr_illegal), 64'(exp_ill));
        chk("load", 64'(instret_load), 64'(exp_load));
        if (exp_load) chk("load_data", instret_data, merged);
        chk("inc_resp", 64'(instret_inc), 64'(ret & ~m_inh_ir & ~exp_load));
        bus.csr_req = 1'b0; retire = 1'b0;
        advance(1'b0, 64'd0);
        chk("ack_drop", 64'(bus.csr_ack), 64'd0);
        chk("load_drop", 64'(instret_load), 64'd0);
    endtask

    logic [11:0] addr_tab [12];

    initial begin
        addr_tab = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                     12'hC02, 12'hC82, 12'h320, 12'h7C0, 12'hB01, 12'h000};
        model_reset();
        rst_n = 1'b0; retire = 1'b1; instret_in = 64'd0;
        bus.csr_req = 1'b1; bus.csr_addr = 12'hB02; bus.csr_op = 2'd1; bus.csr_wdata = 32'hFFFF_FFFF;
        #2;
        repeat (3) begin
            chk("rst_ack", 64'(bus.csr_ack), 64'd0);
            chk("rst_rdata", 64'(bus.csr_rdata), 64'd0);
            chk("rst_illegal", 64'(bus.csr_illegal), 64'd0);
            chk("rst_load", 64'(instret_load), 64'd0);
            chk("rst_data", instret_data, 64'd0);
            chk("rst_inc", 64'(instret_inc), 64'd0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1; bus.csr_req = 1'b0; retire = 1'b0;

        // mcycle counts from zero after reset
        csr_txn(12'hB00, 2'd0, 32'd0, 1'b0);
        csr_txn(12'hB80, 2'd0, 32'd0, 1'b1);
        // plain read of minstret lo
        instret_in = 64'h0000_0001_0000_00F0;
        csr_txn(12'hB02, 2'd0, 32'd0, 1'b0);
        // hi write merges with live lo and drops the concurrent retire
        instret_in = 64'h0000_0000_0000_0005;
        csr_txn(12'hB82, 2'd1, 32'h0000_000A, 1'b1);
        // inhibit instret, then release it
        csr_txn(12'h320, 2'd2, 32'h0000_0004, 1'b0);
        idle(4);
        csr_txn(12'h320, 2'd3, 32'h0000_0004, 1'b1);
        idle(4);
        // read-only alias write and unmapped address
        instret_in = 64'h1234_5678_9ABC_DEF0;
        csr_txn(12'hC02, 2'd1, 32'h5555_AAAA, 1'b0);
        csr_txn(12'h7C0, 2'd0, 32'd0, 1'b0);
        csr_txn(12'hC00, 2'd2, 32'd0, 1'b0);
        csr_txn(12'hB02, 2'd2, 32'd0, 1'b1);
        // mcycle wrap
        csr_txn(12'hB80, 2'd1, 32'hFFFF_FFFF, 1'b0);
        csr_txn(12'hB00, 2'd1, 32'hFFFF_FFFE, 1'b0);
        csr_txn(12'hB00, 2'd0, 32'd0, 1'b0);
        csr_txn(12'hB80, 2'd0, 32'd0, 1'b0);
        // lo read just before rollover, hi read after it
        csr_txn(12'h320, 2'd1, 32'h0000_0001, 1'b0);
        csr_txn(12'hB80, 2'd1, 32'h0000_0000, 1'b0);
        csr_txn(12'hB00, 2'd1, 32'hFFFF_FFFF, 1'b0);
        csr_txn(12'hB00, 2'd0, 32'd0, 1'b0);
        csr_txn(12'h320, 2'd1, 32'h0000_0000, 1'b0);
        idle(3);
        csr_txn(12'hB80, 2'd0, 32'd0, 1'b0);

        // reset in the middle of a transaction: no ack, no load
        instret_in = 64'h0;
        bus.csr_req = 1'b1; bus.csr_addr = 12'hB02; bus.csr_op = 2'd1; bus.csr_wdata = 32'h77;
        advance(1'b0, 64'd0);
        rst_n = 1'b0; bus.csr_req = 1'b0;
        #1;
        chk("midrst_ack", 64'(bus.csr_ack), 64'd0);
        chk("midrst_load", 64'(instret_load), 64'd0);
        chk("midrst_data", instret_data, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        idle(2);
        csr_txn(12'hB00, 2'd0, 32'd0, 1'b0);

        // randomized traffic
        for (int t = 0; t < 200; t++) begin
            instret_in = {$urandom, $urandom};
            csr_txn(addr_tab[$urandom_range(0, 11)], 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom),
                    1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
